// File: rtl/regfile_pkg.sv
// Shared definitions for the decode-stage register file: default geometry and
// the address predicates used by both the storage and the scoreboard logic.
package regfile_pkg;

    localparam int DEF_XLEN  = 32;
    localparam int DEF_NREGS = 32;

    // Address fields are AW bits wide but NREGS need not be a power of two,
    // so the top of the address space may not map to a real register.
    function automatic logic addr_valid(input int unsigned addr, input int unsigned nregs);
        return addr < nregs;
    endfunction

    function automatic logic is_zero_reg(input int unsigned addr, input logic zero_reg);
        return zero_reg && (addr == 0);
    endfunction

endpackage

// File: rtl/regfile_sb.sv
// Multi-read-port integer register file with a pending-write scoreboard.
// Operands are read combinationally; the scoreboard flags registers whose producer has issued but not written back.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int XLEN     = DEF_XLEN,
    parameter int NREGS    = DEF_NREGS,
    parameter int NREAD    = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we3,
    input  logic [AW-1:0]         wa3,
    input  logic [XLEN-1:0]       wd3,
    input  logic [NREAD*AW-1:0]   ra,
    output logic [NREAD*XLEN-1:0] rd,
    input  logic                  alloc_en,
    input  logic [AW-1:0]         alloc_a,
    output logic [NREAD-1:0]      rbusy,
    output logic                  any_pending
);

    localparam logic HAS_ZERO = (ZERO_REG != 0);
    localparam logic HAS_BYP  = (BYPASS != 0);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] pending;

    logic wr_ok;
    logic alloc_ok;

    assign wr_ok    = we3 && addr_valid(32'(wa3), NREGS) && !is_zero_reg(32'(wa3), HAS_ZERO);
    assign alloc_ok = alloc_en && addr_valid(32'(alloc_a), NREGS)
                      && !is_zero_reg(32'(alloc_a), HAS_ZERO);

    // NOTE: the array is flop-based and cleared by the async reset so reads
    // return zero immediately; this deliberately prevents RAM-macro inference.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_ok) begin
            regs[wa3] <= wd3;
        end
    end

    // Alloc is applied after the write clear so a same-cycle producer wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            if (wr_ok) begin
                pending[wa3] <= 1'b0;
            end
            if (alloc_ok) begin
                pending[alloc_a] <= 1'b1;
            end
        end
    end

    assign any_pending = |pending;

    for (genvar i = 0; i < NREAD; i++) begin : g_rd
        logic [AW-1:0]   a;
        logic            a_valid;
        logic            a_zero;
        logic            hit;
        logic [XLEN-1:0] data;
        logic            busy;

        assign a       = ra[i*AW +: AW];
        assign a_valid = addr_valid(32'(a), NREGS);
        assign a_zero  = is_zero_reg(32'(a), HAS_ZERO);
        assign hit     = HAS_BYP && we3 && (wa3 == a);

        always_comb begin
            data = '0;
            busy = 1'b0;
            if (a_valid && !a_zero) begin
                data = hit ? wd3 : regs[a];
                busy = pending[a] && !hit;
            end
        end

        assign rd[i*XLEN +: XLEN] = data;
        assign rbusy[i]           = busy;
    end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised multi-read-port integer register file with an attached pending-write scoreboard, the successor to the lab's fixed 32×32 two-read/one-write register file. Sits in the decode stage of the pipelined core. It supplies operands combinationally, forwards same-cycle write data when bypass is enabled, and reports per-read-port "operand not yet produced" status for the hazard unit.

## Interface
- XLEN, 32: register width in bits.
- NREGS, 32: number of architectural registers (2..64, need not be a power of two).
- AW, $clog2(NREGS): address width (derived, not overridden).
- NREAD, 2: number of read ports (1..4).
- ZERO_REG, 1: 1 = register 0 hardwired to zero, never pending.
- BYPASS, 1: 1 = write-first forwarding of wd3 to matching read ports.

- clk  in  1  system clock, all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- we3  in  1  write enable.
- wa3  in  AW  write address.
- wd3  in  XLEN  write data.
- ra  in  NREAD*AW  read addresses, port i at bits [i*AW +: AW].
- rd  out  NREAD*XLEN  read data, port i at bits [i*XLEN +: XLEN].
- alloc_en  in  1  mark a register as awaiting a write (instruction issue).
- alloc_a  in  AW  register being allocated.
- rbusy  out  NREAD  port i's register is pending and not satisfied this cycle.
- any_pending  out  1  OR of all pending bits.

## Operation
- Storage: NREGS×XLEN array plus NREGS pending bits.
- Write: at posedge clk, if we3 and wa3 is valid, regs[wa3] <= wd3. A write to register 0 with ZERO_REG=1 is discarded. A write to an address ≥ NREGS is discarded.
- Read (combinational), per port i, in priority order:
  - ra_i ≥ NREGS → rd_i = 0.
  - ra_i = 0 and ZERO_REG → rd_i = 0.
  - BYPASS and we3 and wa3 = ra_i → rd_i = wd3.
  - Otherwise rd_i = regs[ra_i].
- Scoreboard, at posedge clk:
  - we3 with valid wa3 clears pending[wa3].
  - alloc_en with valid alloc_a sets pending[alloc_a].
  - Same address in both in the same cycle → pending ends set (the new producer wins).
  - Register 0 (ZERO_REG) and out-of-range addresses are never set.
- rbusy_i = pending[ra_i] and not (BYPASS and we3 and wa3 = ra_i). It is 0 for register 0 and for out-of-range ra_i.
- any_pending is the registered-state OR, with no bypass term.

## Timing
- Reset (rst_n low, asynchronous): every register clears to 0 and every pending bit clears. Consequently every rd = 0, every rbusy = 0 and any_pending = 0 immediately, without a clock.
- Reset deasserting mid-write: that edge's write is not performed.
- Write latency: the value is visible through storage one cycle after the write edge. With BYPASS it is also visible in the same cycle as we3.
- With BYPASS=0, reading the written address in the write cycle returns the old value and rbusy stays asserted until after the edge.
- Alloc latency: rbusy rises the cycle after alloc_en and is not forwarded.
- Multiple read ports on the same address return identical data and busy.

## Structure
- Shared package `regfile_pkg`: default XLEN/NREGS constants, and the `addr_valid` and zero-register predicate functions.
- Single module, no sub-modules. A generate loop over NREAD produces the read/bypass/busy logic.
- The existing lab testbench style (random ra/wa/wd on posedge) is reused, extended with a reference model.

## Test plan
- Assert rst_n=0 after writing 0xDEADBEEF to r5, without a clock → rd for ra=5 reads 0 immediately, any_pending=0.
- we3=1, wa3=0, wd3=0xFFFFFFFF (ZERO_REG=1), then ra={0,0} → rd={0,0}, rbusy=0.
- BYPASS=1: we3=1, wa3=7, wd3=0x12345678, ra0=7 in the same cycle → rd0=0x12345678 combinationally. BYPASS=0 → old value 0 until the next cycle.
- alloc_en, alloc_a=9 at cycle N → rbusy=1 for ra=9 from N+1. Write r9=0xA5 at cycle M → rbusy=0 in cycle M (bypass) and pending cleared after M.
- Same-cycle alloc_a=3 and wa3=3 → after the edge, r3 holds the new data and rbusy for ra=3 stays 1.
- NREGS=24, NREAD=4: write to address 30 ignored, ra=30 → rd=0, rbusy=0. 10k random cycles on all ports match the scoreboard reference model.
